sliced_serial_adder: RTL and testbench
======================================

Name: sliced_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor.
- Adds two WIDTH-bit operands SLICE bits per clock, using a registered carry between slices. This trades latency for a small combinational adder.
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake.
- Sits between operand registers and the result/display path in lab datapaths where a full-width ripple chain is too long.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be an integer multiple of SLICE.
- SLICE, 4, bits added per clock. Legal range 1..WIDTH.
- NSLICE = WIDTH/SLICE is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- sub  input  1  0 = add (a+b+ci), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ci  input  1  carry-in for add; ignored when sub=1; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  result, registered
- co  output  1  carry-out of MSB. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: rst_n=0 immediately forces state=IDLE, busy=0, done=0, sum=0, co=0, ovf=0, and clears the internal operand, carry and slice counter.
  - Release is synchronous to the next clk edge.
- States:
  - IDLE: start=1 at edge E0 moves to RUN.
  - RUN: exactly NSLICE cycles, then back to IDLE. There is no other state.
- Load at edge E0:
  - Internal A register <= a.
  - Internal B register <= (sub ? ~b : b).
  - Carry register <= (sub ? 1 : ci).
  - Slice index k <= 0.
  - busy <= 1, done <= 0.
- Each RUN edge E1..E_NSLICE:
  - Compute slice k: {c, s} = A[k] + B[k] + carry, with SLICE-bit slices, LSB slice first.
  - s goes into the internal result shift register; carry <= c; k <= k+1.
- At edge E_NSLICE:
  - sum <= assembled result; co <= final carry.
  - ovf <= carry into the MSB XOR carry out of the MSB. This requires the MSB-internal carry of the last slice; for SLICE=1 it is the carry register value before the last slice.
  - busy <= 0, done <= 1, state <= IDLE.
- Latency: start edge to done=1 is NSLICE cycles. Throughput is one operation per NSLICE+1 cycles, or NSLICE cycles if start is held.
- done is high exactly one cycle. The start that is high in the done cycle is accepted, giving back-to-back operation.
- sum, co and ovf hold their previous values throughout RUN. They update only at the done edge and hold until the next done or reset. Partial results are never visible.
- start while busy=1 is ignored; no queuing. Changes on a, b, sub and ci during RUN have no effect.
- Degenerate cases:
  - SLICE=WIDTH gives NSLICE=1, a single RUN cycle.
  - SLICE=1 gives a bit-serial adder with NSLICE=WIDTH.
- Wrap-around: the result is modulo 2^WIDTH. Carry beyond the MSB appears only on co.
- Reset asserted mid-RUN aborts the operation. done is never asserted for it, and outputs return to reset values.
- The slice counter width is clog2(NSLICE), with a minimum of 1. Only the value NSLICE-1 terminates RUN.

Test Plan:
- WIDTH=16, SLICE=4:
  - Add: a=0x1234, b=0x4321, ci=0, sub=0 -> done 4 cycles after the start edge, sum=0x5555, co=0, ovf=0. busy is high for exactly 4 cycles.
  - Add with wrap: a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0. a=0x7FFF, b=0x0001, ci=0 -> sum=0x8000, co=0, ovf=1.
  - Carry-in and subtract: a=0x00FF, b=0x0000, ci=1 -> sum=0x0100, co=0. sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, co=0, ovf=0. sub=1 with a=0x8000, b=0x0001 -> sum=0x7FFF, co=1, ovf=1.
  - Handshake: second start (a=0x1111) pulsed mid-RUN -> ignored; first result unchanged and done pulses once. start held high through the done cycle -> next operation begins immediately, with a 4-cycle spacing of done pulses. sum holds the old value during RUN.
  - Reset: rst_n pulled low asynchronously (between edges) at slice 2 -> busy, done, sum, co and ovf become 0 immediately. No done follows. The next start after release completes normally.
- Parametrisation: repeat the add-with-wrap vectors at WIDTH=16, SLICE=1 (16-cycle latency) and SLICE=16 (1-cycle latency) -> identical sum, co and ovf values.

Source files
------------

// File: rtl/sliced_serial_adder.sv
// Multi-cycle adder/subtractor: adds SLICE bits per clock through a registered
// carry, with a start/busy/done handshake and signed-overflow detection.
module sliced_serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, res, res_next;
    logic [KW-1:0]    k;
    logic             carry;
    logic             load, last;
    logic [SLICE-1:0] a_slice, b_slice;
    logic [SLICE:0]   slice_sum;
    logic             msb_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The finishing RUN edge may reload directly, so a held start gives one
    // result every NSLICE cycles.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = (k == K_LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    if (start) load = 1'b1;
                    else       state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        a_slice   = a_reg[int'(k)*SLICE +: SLICE];
        b_slice   = b_reg[int'(k)*SLICE +: SLICE];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry};
        // Carry into the slice MSB recovered from the sum bit; valid for SLICE=1 too.
        msb_cin   = slice_sum[SLICE-1] ^ a_slice[SLICE-1] ^ b_slice[SLICE-1];
        res_next  = res;
        res_next[int'(k)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            k     <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                res   <= res_next;
                carry <= slice_sum[SLICE];
                k     <= k + KW'(1);
                if (last) begin
                    sum  <= res_next;
                    co   <= slice_sum[SLICE];
                    ovf  <= msb_cin ^ slice_sum[SLICE];
                    done <= 1'b1;
                    k    <= '0;
                end
            end
            if (load) begin
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                carry <= sub ? 1'b1 : ci;
                k     <= '0;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_sliced_serial_adder.sv
// Directed self-checking bench for sliced_serial_adder at SLICE=4, 1 and 16.
module tb_sliced_serial_adder;

    logic        clk, rst_n, start, sub, ci;
    logic [15:0] a, b;

    logic        busy4, done4, co4, ovf4;
    logic [15:0] sum4;
    logic        busy1, done1, co1, ovf1;
    logic [15:0] sum1;
    logic        busy16, done16, co16, ovf16;
    logic [15:0] sum16;

    int errors = 0;
    int checks = 0;

    sliced_serial_adder #(.WIDTH(16), .SLICE(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy4), .done(done4), .sum(sum4), .co(co4), .ovf(ovf4));

    sliced_serial_adder #(.WIDTH(16), .SLICE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1));

    sliced_serial_adder #(.WIDTH(16), .SLICE(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge, then count cycles from the start edge to done.
    task automatic run_op(input logic [15:0] aa, input logic [15:0] bb, input logic c,
                          input logic s, output int lat, output int bcnt);
        @(negedge clk);
        a = aa; b = bb; ci = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done4 && lat < 40) begin
            if (busy4) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                            input logic c, input logic s, input logic [15:0] esum,
                            input logic eco, input logic eovf);
        int lat, bcnt;
        run_op(aa, bb, c, s, lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(sum4), 32'(esum));
        chk({tag, "_co"}, 32'(co4), 32'(eco));
        chk({tag, "_ovf"}, 32'(ovf4), 32'(eovf));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done4), 32'd0);
    endtask

    task automatic param_check(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                               input logic [15:0] esum, input logic eco, input logic eovf);
        int l4, l1, l16;
        l4 = -1; l1 = -1; l16 = -1;
        @(negedge clk);
        a = aa; b = bb; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (done4 && l4 < 0) begin
                l4 = i;
                chk({tag, "_s4_val"}, {15'd0, sum4, co4, ovf4}, {15'd0, esum, eco, eovf});
            end
            if (done1 && l1 < 0) begin
                l1 = i;
                chk({tag, "_s1_val"}, {15'd0, sum1, co1, ovf1}, {15'd0, esum, eco, eovf});
            end
            if (done16 && l16 < 0) begin
                l16 = i;
                chk({tag, "_s16_val"}, {15'd0, sum16, co16, ovf16}, {15'd0, esum, eco, eovf});
            end
            @(negedge clk);
        end
        chk({tag, "_s4_lat"}, 32'(l4), 32'd4);
        chk({tag, "_s1_lat"}, 32'(l1), 32'd16);
        chk({tag, "_s16_lat"}, 32'(l16), 32'd1);
    endtask

    initial begin
        int lat, bcnt, nd, d1, d2;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;

        repeat (2) @(negedge clk);
        chk("reset_state", {27'd0, busy4, done4, co4, ovf4, |sum4}, 32'd0);
        rst_n = 1'b1;

        // Basic add with latency and busy width
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, bcnt);
        chk("add_lat", 32'(lat), 32'd4);
        chk("add_busy_cycles", 32'(bcnt), 32'd4);
        chk("add_sum", 32'(sum4), 32'h5555);
        chk("add_co_ovf", {30'd0, co4, ovf4}, 32'd0);
        @(negedge clk);
        chk("add_done_pulse", 32'(done4), 32'd0);

        op_check("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_check("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_check("carry_in", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        op_check("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op_check("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start pulsed mid-RUN must be ignored; old sum holds during RUN
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrun_hold_sum", 32'(sum4), 32'h7FFF);
        start = 1'b1; a = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) nd++;
            @(negedge clk);
        end
        chk("midrun_done_count", 32'(nd), 32'd1);
        chk("midrun_sum", 32'(sum4), 32'h5555);

        // Start held through the done cycle: back-to-back with 4-cycle spacing
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h0010; b = 16'h0020;
        nd = 0; d1 = -1; d2 = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done4) begin
                nd++;
                if (nd == 1) begin
                    d1 = i;
                    chk("b2b_sum1", 32'(sum4), 32'h0002);
                    chk("b2b_busy", 32'(busy4), 32'd1);
                end else if (nd == 2) begin
                    d2 = i;
                    chk("b2b_sum2", 32'(sum4), 32'h0030);
                end
            end
            if (i == 4) start = 1'b0;
            if (i == 6) chk("b2b_hold_sum", 32'(sum4), 32'h0002);
        end
        chk("b2b_first_done", 32'(d1), 32'd4);
        chk("b2b_second_done", 32'(d2), 32'd8);
        chk("b2b_done_count", 32'(nd), 32'd2);

        // Asynchronous reset in the middle of RUN
        op_check("pre_reset", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_sum", 32'(sum4), 32'd0);
        chk("abort_co_ovf", {30'd0, co4, ovf4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        op_check("post_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Same vectors across slice widths once every instance is idle
        repeat (20) @(negedge clk);
        param_check("par_ffff", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        param_check("par_7fff", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
